io_bus_arbiter: RTL and testbench
=================================

# io_bus_arbiter

Sequential arbiter and transaction sequencer that lets several masters share the single IO bus (address/ctrl/data to main RAM and the memory-mapped switch/LED/seven-segment peripherals). It sits between the CPU-side master ports (instruction fetch, load/store, future DMA) and the bus decoder. Each transaction runs through an address-region-dependent wait counter because the bus has no ready line. It also rejects unmapped peripheral addresses with an error response.

## Interface
- N_MASTER, 3: number of requesting masters; master 0 is instruction fetch, 1 is load/store, 2 is spare/DMA.
- RAM_WAIT, 1: extra ACCESS cycles for main-RAM addresses (0..15).
- PERIPH_WAIT, 2: extra ACCESS cycles for peripheral addresses (0..15).

- clk  in  1  single clock; everything in this block is synchronous to its rising edge.
- rst  in  1  reset, synchronous and active-high.
- m_req  in  N_MASTER  per-master request; held until that master's ack or err.
- m_we  in  N_MASTER  per-master write flag.
- m_addr  in  N_MASTER*`IO_BUS_WIDTH_ADDR  flattened addresses; master i occupies slice i.
- m_ctrl  in  N_MASTER*`IO_BUS_WIDTH_CTRL  flattened ctrl words; must be nonzero while requesting.
- m_wdata  in  N_MASTER*`IO_BUS_WIDTH_DATA  flattened write data.
- m_gnt  out  N_MASTER  one-hot grant, high for the whole ACCESS phase.
- m_ack  out  N_MASTER  one-cycle completion pulse.
- m_err  out  N_MASTER  one-cycle error pulse, used for unmapped addresses.
- m_rdata  out  `IO_BUS_WIDTH_DATA  read data, valid in the ack cycle and shared by all masters.
- bus_addr  out  `IO_BUS_WIDTH_ADDR  address to the bus decoder.
- bus_ctrl  out  `IO_BUS_WIDTH_CTRL  ctrl to the bus; 0 means no operation.
- bus_wdata  out  `IO_BUS_WIDTH_DATA  write data for the top-level tristate driver.
- bus_drive  out  1  tristate enable; high only during a write ACCESS.
- bus_rdata  in  `IO_BUS_WIDTH_DATA  data sampled from the bus.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states are IDLE, ACCESS and DONE.
- **IDLE**
  - If any m_req is high, the arbiter picks a winner and latches its addr, ctrl, wdata and we.
  - It classifies the address:
    - RAM when addr[31:12] != 20'hFFFFF, wait count = RAM_WAIT.
    - Peripheral when addr[31:12] == 20'hFFFFF and addr[7:4] is in {0,1,6,7}, wait count = PERIPH_WAIT.
    - Otherwise unmapped.
  - Mapped addresses go to ACCESS. Unmapped addresses go straight to DONE with the error flag set, and the bus is never driven.
- **ACCESS**
  - bus_addr, bus_ctrl and bus_wdata come from the latched values; bus_drive = latched we; m_gnt[winner] = 1.
  - The counter decrements each cycle. On the cycle the counter is 0, bus_rdata is captured into the rdata register and the FSM goes to DONE.
  - ACCESS therefore lasts wait+1 cycles.
- **DONE**
  - One cycle of m_ack[winner], or m_err[winner] with m_rdata = 0.
  - Bus outputs return to 0. The FSM always goes to IDLE next.
  - Because of this IDLE bubble, a master that drops m_req in the cycle after its ack is never re-granted spuriously.
- **Arbitration** is combinational over m_req using the rotate pointer `ptr`, which is only used when IO_ARB_ROUND_ROBIN_EN is defined:
  - The winner is the first requesting index at or after ptr, modulo N_MASTER.
  - ptr ← winner+1 (wrapping) when entering DONE.
- A request raised mid-transaction waits; it is sampled only in IDLE. Withdrawing a request before ack is illegal; the transaction completes anyway.
- Outputs are all registered from FSM state and latches; no m_* input reaches a bus_* output combinationally.

## Timing
- Reset: state=IDLE, ptr=0. m_gnt, m_ack, m_err, m_rdata, bus_addr, bus_ctrl, bus_wdata, bus_drive and busy are all 0.
- rst asserted mid-ACCESS aborts the transaction. The next cycle shows reset values and no ack is issued.
- Taking the cycle in which m_req is seen high in IDLE as T:
  - ACCESS runs from T+1 to T+1+wait.
  - ack or err is at T+2+wait.
  - An unmapped address gives err at T+1.
- RAM transaction with default parameters: ack at T+3.
- Peak throughput: one transaction per wait+3 cycles.
- Simultaneous requests in IDLE resolve in the same cycle; the loser is served in the earliest following IDLE cycle in which it wins.

## Configuration
- IO_ARB_ROUND_ROBIN_EN defined: rotating priority through ptr as described, giving starvation-free service.
- IO_ARB_ROUND_ROBIN_EN undefined:
  - Fixed priority; the lowest index wins.
  - ptr is not implemented.
  - Master 0 can starve the others.

## Structure
- Shared package or param.v holds:
  - `IO_BUS_WIDTH_ADDR/CTRL/DATA.
  - Region constants: 20'hFFFFF peripheral page and the peripheral addr[7:4] codes 0, 1, 6, 7.
  - FSM state encodings IO_ARB_IDLE, IO_ARB_ACCESS, IO_ARB_DONE.
- One sub-module, rr_arbiter: combinational pick of a one-hot winner from req and ptr. Under the macro-off build it degenerates to a priority encoder.

## Test plan
- Single RAM read: master 1 reads addr 0x0000_0100, bus_rdata=0xDEADBEEF → bus_ctrl nonzero for 2 cycles, m_ack[1] at T+3, m_rdata=0xDEADBEEF.
- Peripheral write: master 1 writes addr 0xFFFF_F060 with data 0x5A → bus_drive high for exactly 3 cycles, ack at T+4.
- Unmapped: addr 0xFFFF_F030 → bus_ctrl stays 0, m_err[1] at T+1, m_rdata=0.
- Contention: masters 0, 1 and 2 requesting continuously with round-robin on → grant order 0, 1, 2, 0. With the macro off → 0, 0, 0.
- Reset mid-ACCESS: rst at T+2 of a PERIPH access → no ack, all outputs 0 the next cycle; a re-request is served normally.
- Back-to-back: master 0 re-requests the cycle after its ack → exactly one IDLE cycle between DONE and the next ACCESS.

Source files
------------

// File: rtl/io_bus_arbiter_pkg.sv
// Shared widths, address-region constants and FSM encodings for io_bus_arbiter.
// The optional IO_ARB_ROUND_ROBIN_EN macro is consumed by rr_arbiter and io_bus_arbiter.
`ifndef IO_BUS_WIDTH_ADDR
`define IO_BUS_WIDTH_ADDR 32
`endif
`ifndef IO_BUS_WIDTH_CTRL
`define IO_BUS_WIDTH_CTRL 4
`endif
`ifndef IO_BUS_WIDTH_DATA
`define IO_BUS_WIDTH_DATA 32
`endif

package io_bus_arbiter_pkg;

    localparam logic [19:0] IO_PERIPH_PAGE = 20'hFFFFF;
    localparam logic [3:0]  IO_PERIPH_SW   = 4'h0;
    localparam logic [3:0]  IO_PERIPH_LED  = 4'h1;
    localparam logic [3:0]  IO_PERIPH_SEG0 = 4'h6;
    localparam logic [3:0]  IO_PERIPH_SEG1 = 4'h7;

    typedef enum logic [1:0] {
        IO_ARB_IDLE   = 2'd0,
        IO_ARB_ACCESS = 2'd1,
        IO_ARB_DONE   = 2'd2
    } io_arb_state_e;

    typedef enum logic [1:0] {
        IO_REG_RAM      = 2'd0,
        IO_REG_PERIPH   = 2'd1,
        IO_REG_UNMAPPED = 2'd2
    } io_region_e;

    // Everything outside the top 4 KiB page is RAM; inside it only four blocks decode.
    function automatic io_region_e io_classify(input logic [`IO_BUS_WIDTH_ADDR-1:0] a);
        io_region_e r;
        r = IO_REG_UNMAPPED;
        if (a[31:12] != IO_PERIPH_PAGE) begin
            r = IO_REG_RAM;
        end else begin
            case (a[7:4])
                IO_PERIPH_SW, IO_PERIPH_LED, IO_PERIPH_SEG0, IO_PERIPH_SEG1: r = IO_REG_PERIPH;
                default: r = IO_REG_UNMAPPED;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot winner pick. With IO_ARB_ROUND_ROBIN_EN the search starts at
// i_ptr and wraps; without it this is a lowest-index-wins priority encoder.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
`ifdef IO_ARB_ROUND_ROBIN_EN
    input  logic [IW-1:0] i_ptr,
`endif
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

`ifdef IO_ARB_ROUND_ROBIN_EN
    logic w_found;
    int   w_i;

    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_i     = 0;
        for (int k = 0; k < N; k++) begin
            w_i = int'(i_ptr) + k;
            if (w_i >= N) w_i = w_i - N;
            if (!w_found && i_req[w_i]) begin
                w_found    = 1'b1;
                o_gnt[w_i] = 1'b1;
                o_idx      = IW'(w_i);
            end
        end
    end
`else
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[k]) begin
                o_gnt    = '0;
                o_gnt[k] = 1'b1;
                o_idx    = IW'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/io_bus_arbiter.sv
// Multi-master IO bus arbiter/sequencer with region-dependent wait counts and
// unmapped-address error responses. IO_ARB_ROUND_ROBIN_EN selects rotating priority.
module io_bus_arbiter
    import io_bus_arbiter_pkg::*;
#(
    parameter int N_MASTER    = 3,
    parameter int RAM_WAIT    = 1,
    parameter int PERIPH_WAIT = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_MASTER-1:0]                    m_req,
    input  logic [N_MASTER-1:0]                    m_we,
    input  logic [N_MASTER*`IO_BUS_WIDTH_ADDR-1:0] m_addr,
    input  logic [N_MASTER*`IO_BUS_WIDTH_CTRL-1:0] m_ctrl,
    input  logic [N_MASTER*`IO_BUS_WIDTH_DATA-1:0] m_wdata,
    output logic [N_MASTER-1:0]                    m_gnt,
    output logic [N_MASTER-1:0]                    m_ack,
    output logic [N_MASTER-1:0]                    m_err,
    output logic [`IO_BUS_WIDTH_DATA-1:0]          m_rdata,
    output logic [`IO_BUS_WIDTH_ADDR-1:0]          bus_addr,
    output logic [`IO_BUS_WIDTH_CTRL-1:0]          bus_ctrl,
    output logic [`IO_BUS_WIDTH_DATA-1:0]          bus_wdata,
    output logic                                   bus_drive,
    input  logic [`IO_BUS_WIDTH_DATA-1:0]          bus_rdata,
    output logic                                   busy
);

    localparam int AW = `IO_BUS_WIDTH_ADDR;
    localparam int CW = `IO_BUS_WIDTH_CTRL;
    localparam int DW = `IO_BUS_WIDTH_DATA;
    localparam int IW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    logic [N_MASTER-1:0] w_gnt;
    logic [IW-1:0]       w_idx;
    logic [AW-1:0]       w_addr;
    io_region_e          w_region;

    io_arb_state_e       r_state;
    logic [3:0]          r_cnt;
    logic [N_MASTER-1:0] r_gnt;
    logic [N_MASTER-1:0] r_ack;
    logic [N_MASTER-1:0] r_err;
    logic [DW-1:0]       r_rdata;
    logic [AW-1:0]       r_bus_addr;
    logic [CW-1:0]       r_bus_ctrl;
    logic [DW-1:0]       r_bus_wdata;
    logic                r_bus_drive;
    logic                r_busy;

`ifdef IO_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] r_ptr;
    logic [IW-1:0] r_widx;

    function automatic logic [IW-1:0] f_next(input logic [IW-1:0] i);
        return (int'(i) == N_MASTER - 1) ? '0 : i + 1'b1;
    endfunction
`endif

    rr_arbiter #(.N(N_MASTER), .IW(IW)) u_arb (
        .i_req (m_req),
`ifdef IO_ARB_ROUND_ROBIN_EN
        .i_ptr (r_ptr),
`endif
        .o_gnt (w_gnt),
        .o_idx (w_idx)
    );

    assign w_addr   = m_addr[int'(w_idx)*AW +: AW];
    assign w_region = io_classify(w_addr);

    // Bus outputs double as the transaction latch: loaded in IDLE, held through ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IO_ARB_IDLE;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_ack       <= '0;
            r_err       <= '0;
            r_rdata     <= '0;
            r_bus_addr  <= '0;
            r_bus_ctrl  <= '0;
            r_bus_wdata <= '0;
            r_bus_drive <= 1'b0;
            r_busy      <= 1'b0;
`ifdef IO_ARB_ROUND_ROBIN_EN
            r_ptr       <= '0;
            r_widx      <= '0;
`endif
        end else begin
            r_ack <= '0;
            r_err <= '0;
            case (r_state)
                IO_ARB_IDLE: begin
                    if (|m_req) begin
                        r_busy <= 1'b1;
`ifdef IO_ARB_ROUND_ROBIN_EN
                        r_widx <= w_idx;
`endif
                        if (w_region == IO_REG_UNMAPPED) begin
                            r_state <= IO_ARB_DONE;
                            r_err   <= w_gnt;
                            r_rdata <= '0;
`ifdef IO_ARB_ROUND_ROBIN_EN
                            r_ptr   <= f_next(w_idx);
`endif
                        end else begin
                            r_state     <= IO_ARB_ACCESS;
                            r_gnt       <= w_gnt;
                            r_cnt       <= (w_region == IO_REG_RAM) ? 4'(RAM_WAIT) : 4'(PERIPH_WAIT);
                            r_bus_addr  <= w_addr;
                            r_bus_ctrl  <= m_ctrl[int'(w_idx)*CW +: CW];
                            r_bus_wdata <= m_wdata[int'(w_idx)*DW +: DW];
                            r_bus_drive <= m_we[w_idx];
                        end
                    end
                end
                IO_ARB_ACCESS: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= IO_ARB_DONE;
                        r_rdata     <= bus_rdata;
                        r_ack       <= r_gnt;
                        r_gnt       <= '0;
                        r_bus_addr  <= '0;
                        r_bus_ctrl  <= '0;
                        r_bus_wdata <= '0;
                        r_bus_drive <= 1'b0;
`ifdef IO_ARB_ROUND_ROBIN_EN
                        r_ptr       <= f_next(r_widx);
`endif
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= IO_ARB_IDLE;
                    r_rdata <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign m_gnt     = r_gnt;
    assign m_ack     = r_ack;
    assign m_err     = r_err;
    assign m_rdata   = r_rdata;
    assign bus_addr  = r_bus_addr;
    assign bus_ctrl  = r_bus_ctrl;
    assign bus_wdata = r_bus_wdata;
    assign bus_drive = r_bus_drive;
    assign busy      = r_busy;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed table-driven bench for io_bus_arbiter plus contention, reset-abort and
// back-to-back sequences. Expected contention order follows IO_ARB_ROUND_ROBIN_EN.
module tb_io_bus_arbiter;
    import io_bus_arbiter_pkg::*;

    localparam int N  = 3;
    localparam int AW = `IO_BUS_WIDTH_ADDR;
    localparam int CW = `IO_BUS_WIDTH_CTRL;
    localparam int DW = `IO_BUS_WIDTH_DATA;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    m_req, m_we, m_gnt, m_ack, m_err;
    logic [N*AW-1:0] m_addr;
    logic [N*CW-1:0] m_ctrl;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata, bus_wdata, bus_rdata;
    logic [AW-1:0]   bus_addr;
    logic [CW-1:0]   bus_ctrl;
    logic            bus_drive, busy;

    int checks   = 0;
    int failures = 0;

    io_bus_arbiter #(.N_MASTER(N), .RAM_WAIT(1), .PERIPH_WAIT(2)) dut (
        .clk(clk), .rst(rst), .m_req(m_req), .m_we(m_we), .m_addr(m_addr),
        .m_ctrl(m_ctrl), .m_wdata(m_wdata), .m_gnt(m_gnt), .m_ack(m_ack),
        .m_err(m_err), .m_rdata(m_rdata), .bus_addr(bus_addr), .bus_ctrl(bus_ctrl),
        .bus_wdata(bus_wdata), .bus_drive(bus_drive), .bus_rdata(bus_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] brd;
        int          lat;
        int          acc;
        int          drv;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_master(input int m, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata);
        m_we[m]               = we;
        m_addr[m*AW +: AW]    = addr;
        m_ctrl[m*CW +: CW]    = we ? CW'(2) : CW'(1);
        m_wdata[m*DW +: DW]   = wdata;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int lat = 0, acc = 0, drv = 0, gok = 0, dok = 0, bsy = 0;
        logic [N-1:0]  ack_s = '0, err_s = '0, exp_one;
        logic [31:0]   rd_s = '0;
        exp_one = '0;
        exp_one[v.m] = 1'b1;
        @(negedge clk);
        set_master(v.m, v.we, v.addr, v.wdata);
        bus_rdata = v.brd;
        m_req = '0;
        m_req[v.m] = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) bsy++;
            if (bus_ctrl != '0) begin
                acc++;
                if (m_gnt == exp_one && bus_addr == v.addr && bus_ctrl == (v.we ? CW'(2) : CW'(1))) gok++;
            end
            if (bus_drive) begin
                drv++;
                if (bus_wdata == v.wdata) dok++;
            end
            if (m_ack != '0 || m_err != '0) begin
                lat = c; ack_s = m_ack; err_s = m_err; rd_s = m_rdata;
                m_req = '0;
                break;
            end
        end
        if (lat == 0) m_req = '0;
        chk({tag, " latency"}, 64'(lat), 64'(v.lat));
        chk({tag, " access cycles"}, 64'(acc), 64'(v.acc));
        chk({tag, " gnt/addr/ctrl ok"}, 64'(gok), 64'(v.acc));
        chk({tag, " drive cycles"}, 64'(drv), 64'(v.drv));
        chk({tag, " wdata ok"}, 64'(dok), 64'(v.drv));
        chk({tag, " busy cycles"}, 64'(bsy), 64'(v.lat));
        chk({tag, " ack"}, 64'(ack_s), v.err ? 64'(0) : 64'(exp_one));
        chk({tag, " err"}, 64'(err_s), v.err ? 64'(exp_one) : 64'(0));
        chk({tag, " rdata"}, 64'(rd_s), 64'(v.rdata));
    endtask

    initial begin
        int order[$];
        int exp_ord[$];
        logic [N-1:0] prev;
        int extra;

        //          m  we    addr           wdata          bus_rdata      lat acc drv err  rdata
        tbl[0] = '{1, 1'b0, 32'h0000_0100, 32'h0,         32'hDEADBEEF,  3,  2,  0, 1'b0, 32'hDEADBEEF};
        tbl[1] = '{1, 1'b1, 32'hFFFF_F060, 32'h0000_005A, 32'h0,         4,  3,  3, 1'b0, 32'h0};
        tbl[2] = '{1, 1'b0, 32'hFFFF_F030, 32'h0,         32'h12345678,  1,  0,  0, 1'b1, 32'h0};
        tbl[3] = '{0, 1'b0, 32'hFFFF_F000, 32'h0,         32'h0000_000F, 4,  3,  0, 1'b0, 32'h0000_000F};
        tbl[4] = '{2, 1'b0, 32'hFFFF_F070, 32'h0,         32'hCAFE0001,  4,  3,  0, 1'b0, 32'hCAFE0001};
        tbl[5] = '{2, 1'b1, 32'h8000_1000, 32'h11223344,  32'h0,         3,  2,  2, 1'b0, 32'h0};
        tbl[6] = '{0, 1'b0, 32'hFFFF_E0F0, 32'h0,         32'hA5A5A5A5,  3,  2,  0, 1'b0, 32'hA5A5A5A5};
        tbl[7] = '{0, 1'b0, 32'hFFFF_F0F0, 32'h0,         32'h55555555,  1,  0,  0, 1'b1, 32'h0};
        tbl[8] = '{1, 1'b0, 32'hFFFF_F010, 32'h0,         32'h0000_0001, 4,  3,  0, 1'b0, 32'h0000_0001};
        tbl[9] = '{1, 1'b1, 32'hFFFF_F020, 32'h0000_00FF, 32'h0,         1,  0,  0, 1'b1, 32'h0};

        rst = 1'b1; m_req = '0; m_we = '0; m_addr = '0; m_ctrl = '0; m_wdata = '0;
        bus_rdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        chk("reset gnt/ack/err/drive/busy", 64'({m_gnt, m_ack, m_err, bus_drive, busy}), 64'(0));
        chk("reset m_rdata", 64'(m_rdata), 64'(0));
        chk("reset bus_addr", 64'(bus_addr), 64'(0));
        chk("reset bus_ctrl", 64'(bus_ctrl), 64'(0));
        chk("reset bus_wdata", 64'(bus_wdata), 64'(0));
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Contention: all masters requesting continuously.
        @(negedge clk);
        for (int i = 0; i < N; i++) set_master(i, 1'b0, 32'h0000_0010 * (i + 1), 32'h0);
        bus_rdata = 32'h0;
        m_req = '1;
`ifdef IO_ARB_ROUND_ROBIN_EN
        exp_ord = '{0, 1, 2, 0};
`else
        exp_ord = '{0, 0, 0};
`endif
        prev = '0;
        for (int c = 0; c < 60 && order.size() < exp_ord.size(); c++) begin
            @(negedge clk);
            if (m_gnt != '0 && prev == '0)
                for (int k = 0; k < N; k++) if (m_gnt[k]) order.push_back(k);
            prev = m_gnt;
        end
        m_req = '0;
        chk("contention grant count", 64'(order.size()), 64'(exp_ord.size()));
        for (int k = 0; k < exp_ord.size(); k++)
            chk($sformatf("contention grant %0d", k),
                64'(k < order.size() ? order[k] : -1), 64'(exp_ord[k]));
        for (int c = 0; c < 10 && busy; c++) @(negedge clk);
        chk("contention drains to idle", 64'(busy), 64'(0));

        // Reset asserted during the second ACCESS cycle of a peripheral read.
        @(negedge clk);
        set_master(1, 1'b0, 32'hFFFF_F060, 32'h0);
        bus_rdata = 32'h7777_7777;
        m_req = 3'b010;
        @(negedge clk);
        chk("abort gnt at T+1", 64'(m_gnt), 64'(3'b010));
        @(negedge clk);
        rst = 1'b1;
        m_req = '0;
        @(negedge clk);
        chk("abort outputs zero", 64'({m_gnt, m_ack, m_err, bus_drive, busy, bus_ctrl}), 64'(0));
        chk("abort addr/rdata zero", 64'({bus_addr, m_rdata}), 64'(0));
        rst = 1'b0;
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_ack != '0 || m_err != '0) extra++;
        end
        chk("abort no late ack", 64'(extra), 64'(0));
        run_txn(tbl[1], "after-abort");

        // Back-to-back: master 0 re-requests the cycle after its ack.
        run_txn(tbl[6], "b2b-first");
        @(negedge clk);
        chk("b2b idle bubble", 64'({busy, m_gnt}), 64'(0));
        set_master(0, 1'b0, 32'h0000_0200, 32'h0);
        bus_rdata = 32'h0BAD_F00D;
        m_req = 3'b001;
        @(negedge clk);
        chk("b2b second access starts", 64'({m_gnt, bus_ctrl}), 64'({3'b001, CW'(1)}));
        extra = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (m_ack[0]) begin extra = c + 1; break; end
        end
        m_req = '0;
        chk("b2b second ack delay", 64'(extra), 64'(2));
        chk("b2b second rdata", 64'(m_rdata), 64'(32'h0BAD_F00D));

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
